fetch_queue: RTL and testbench

//  Instruction prefetch buffer between the fetch stage and decode. Captures the
//  (IR, PC4) pair the fetch stage presents each cycle, queues up to DEPTH

---
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode.
// Captures {IR, PC+4} from fetch at the edge where the PC advances, holds up
// to DEPTH entries and presents a show-ahead head entry to decode.
// A redirect (flush) drops every queued and in-flight instruction.
module fetch_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                f_ir,
    input  logic [31:0]                f_pc4,
    output logic                       fetch_en,
    input  logic                       flush,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [31:0]                id_ir,
    output logic [31:0]                id_pc4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic push;
    logic pop;

    assign full     = (count_q == FULL_CNT);
    assign id_valid = (count_q != '0);

    // Flush forces fetch_en high so fetch loads the redirect target; a full
    // queue still advances fetch when decode frees the head this cycle.
    assign fetch_en = !reset && (flush || !full || id_ready);
    assign push     = fetch_en && !flush;
    assign pop      = id_valid && id_ready && !flush;

    assign id_ir  = id_valid ? mem_q[rd_ptr_q][63:32] : NOP;
    assign id_pc4 = id_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
    assign count  = count_q;

    // Next-state for pointers and occupancy; pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Pointer/occupancy registers; reset overrides flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= {f_ir, f_pc4};
    end

    // Underflow and overflow must be impossible by construction.
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && count_q == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard model of queue contents.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] f_ir = '0;
    logic [31:0] f_pc4 = '0;
    logic        fetch_en;
    logic        flush = 1'b0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_ir;
    logic [31:0] id_pc4;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .NOP(32'h0)) dut (
        .clk(clk), .reset(reset), .f_ir(f_ir), .f_pc4(f_pc4),
        .fetch_en(fetch_en), .flush(flush), .id_ready(id_ready),
        .id_valid(id_valid), .id_ir(id_ir), .id_pc4(id_pc4), .count(count)
    );

    always #5 clk = ~clk;

    logic [63:0] sb[$];
    logic [31:0] popped[$];
    logic [31:0] pc;
    int total = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    function automatic logic [31:0] ir_of(input logic [31:0] p);
        return 32'h1300_0000 | p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check against the model, advance model, clock.
    task automatic tick(input bit rdy, input bit fl, input bit rst, input logic [31:0] tgt);
        bit exp_fe, exp_push, exp_pop;
        logic [63:0] head;
        id_ready = rdy;
        flush    = fl;
        reset    = rst;
        f_ir     = ir_of(pc);
        f_pc4    = pc + 32'd4;
        #2;
        exp_fe   = !rst && (fl || sb.size() != DEPTH || rdy);
        exp_push = exp_fe && !fl;
        exp_pop  = (sb.size() != 0) && rdy && !fl;
        chk("fetch_en", 32'(fetch_en), 32'(exp_fe));
        if (chk_on) begin
            head = (sb.size() != 0) ? sb[0] : 64'h0;
            chk("count",    32'(count),    32'(sb.size()));
            chk("id_valid", 32'(id_valid), 32'(sb.size() != 0));
            chk("id_ir",    id_ir,  head[63:32]);
            chk("id_pc4",   id_pc4, head[31:0]);
        end
        if (rst) begin
            sb.delete();
            pc = 32'h3000;
        end else if (fl) begin
            sb.delete();
            pc = tgt;
        end else begin
            if (exp_pop) begin
                void'(sb.pop_front());
                popped.push_back(id_pc4);
            end
            if (exp_push) begin
                sb.push_back({ir_of(pc), pc + 32'd4});
                pc = pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        chk_on = 1'b1;
    endtask

    initial begin
        pc = 32'h3000;
        // reset
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ir", id_ir, 32'h0);

        // 1: fill with decode stalled
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_pc4", id_pc4, 32'h3004);
        chk("full_ir", id_ir, 32'h1300_3000);

        // 2: full queue, decode ready -> push and pop each cycle
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
        chk("stream_pc4", id_pc4, 32'h3014);

        // 3: restart at 0x3000, toggle ready, pointers wrap
        tick(0, 1, 0, 32'h3000);
        popped.delete();
        for (int i = 0; i < 24; i++) tick(~i[0], 0, 0, 0);
        chk("wrap_npop_ge10", 32'(popped.size() >= 10), 32'd1);
        for (int k = 0; k < 10; k++)
            if (k < popped.size()) chk("wrap_order", popped[k], 32'h3004 + 32'(4 * k));

        // 4/5: count=3 then flush to 0x3100
        tick(0, 1, 0, 32'h3000);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        chk("pre_flush_cnt", 32'(count), 32'd3);
        tick(1, 1, 0, 32'h3100);
        chk("post_flush_valid", 32'(id_valid), 32'd0);
        chk("post_flush_ir", id_ir, 32'h0);
        tick(0, 0, 0, 0);
        chk("redirect_valid", 32'(id_valid), 32'd1);
        chk("redirect_pc4", id_pc4, 32'h3104);

        // 6: reset and flush together with count=2
        tick(0, 1, 0, 32'h3000);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("pre_rst_cnt", 32'(count), 32'd2);
        tick(1, 1, 1, 32'h3100);
        chk("rst_flush_cnt", 32'(count), 32'd0);
        tick(0, 0, 0, 0);
        chk("refill_pc4", id_pc4, 32'h3004);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
